// File: rtl/fifo_reader.sv
// fifo_reader: pops a 1-cycle-latency FIFO into a 2-entry valid/ready buffer.
// Optional accepted-word counter enabled by FIFO_READER_STATS_EN.
module fifo_reader #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  idle,
  output logic                  err,
  output logic [CNT_WIDTH-1:0]  word_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t                state_q;
  logic                  idle_q;
  logic                  err_q;
  logic                  inflight_q;
  logic [1:0]            occ_q, occ_d;
  logic [FIFO_WIDTH-1:0] head_q, head_d;
  logic [FIFO_WIDTH-1:0] tail_q, tail_d;
  logic                  pop;
  logic                  cap;
  logic [2:0]            need;

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = head_q;
  assign idle    = idle_q;
  assign err     = err_q;

  assign pop  = m_valid && m_ready;
  assign cap  = inflight_q && !fifo_underflow;
  assign need = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

  assign fifo_rd_en = (state_q == S_RUN) && !fifo_empty
                    && (need < 3'd2);

  // Head always holds the oldest word; tail only used when two are held.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({cap, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = fifo_data_out;
        else               tail_d = fifo_data_out;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        if (occ_q == 2'd2) head_d = tail_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = fifo_data_out;
        end else begin
          head_d = tail_q;
          tail_d = fifo_data_out;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q      <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      inflight_q <= fifo_rd_en;
      if (inflight_q && fifo_underflow) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idle_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_q <= S_RUN;
            idle_q  <= 1'b0;
          end
        end
        S_RUN: begin
          if (!enable) state_q <= S_FLUSH;
        end
        S_FLUSH: begin
          if (enable) begin
            state_q <= S_RUN;
          end else if (!inflight_q && occ_q == 2'd0) begin
            state_q <= S_IDLE;
            idle_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          idle_q  <= 1'b1;
        end
      endcase
    end
  end

`ifdef FIFO_READER_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt_q <= '0;
    else if (pop) cnt_q <= cnt_q + CNT_WIDTH'(1);
  end

  assign word_count = cnt_q;
`else
  assign word_count = '0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: FIFO model + scoreboard around fifo_reader.
// Directed phases with random data and random backpressure.
module tb_fifo_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        fifo_empty;
  logic        fifo_underflow;
  logic [15:0] fifo_data_out;
  logic        fifo_rd_en;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_ready;
  logic        idle;
  logic        err;
  logic [15:0] word_count;

  fifo_reader #(.FIFO_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .fifo_empty    (fifo_empty),
    .fifo_underflow(fifo_underflow),
    .fifo_data_out (fifo_data_out),
    .fifo_rd_en    (fifo_rd_en),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_ready       (m_ready),
    .idle          (idle),
    .err           (err),
    .word_count    (word_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] fq[$];
  logic [15:0] exp_q[$];
  logic        force_empty = 1'b0;
  logic        uf_req = 1'b0;
  logic        rd_seen;
  logic [15:0] w;

  int cyc = 0;
  int rd_cnt, acc_cnt, first_rd, last_rd, first_acc, last_acc;
  int outstanding = 0;
  int exp_wc = 0;
  int en_cyc;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] wc_exp();
`ifdef FIFO_READER_STATS_EN
    return {16'h0, exp_wc[15:0]};
`else
    return 32'h0;
`endif
  endfunction

  always @(posedge clk) cyc++;

  // FIFO with one-cycle read latency; data updates just after the edge.
  always @(posedge clk) begin
    rd_seen = fifo_rd_en && !rst;
    #1;
    fifo_underflow = 1'b0;
    if (rd_seen) begin
      if (fq.size() == 0) begin
        fifo_underflow = 1'b1;
        outstanding--;
      end else begin
        w = fq.pop_front();
        fifo_data_out = w;
        if (uf_req) begin
          fifo_underflow = 1'b1;
          uf_req = 1'b0;
          outstanding--;
        end else begin
          exp_q.push_back(w);
        end
      end
    end
    fifo_empty = force_empty || (fq.size() == 0);
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {31'h0, m_valid}, 32'h1);
        chk("hold_data", {16'h0, m_data}, {16'h0, prev_data});
      end
      if (fifo_rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
        outstanding++;
        chk("rd_when_empty", {31'h0, fifo_empty}, 32'h0);
      end
      if (m_valid && m_ready) begin
        acc_cnt++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        exp_wc++;
        outstanding--;
        if (exp_q.size() == 0)
          chk("sb_extra_word", {31'h0, m_valid}, 32'h0);
        else
          chk("sb_data", {16'h0, m_data}, {16'h0, exp_q.pop_front()});
      end
      chk("outstanding_le2", {31'h0, outstanding <= 2}, 32'h1);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clr();
    rd_cnt = 0; acc_cnt = 0;
    first_rd = -1; last_rd = -1;
    first_acc = -1; last_acc = -1;
  endtask

  task automatic wait_acc(input int n, input int budget);
    for (int i = 0; i < budget && acc_cnt < n; i++) step(1);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; m_ready = 1'b0;
    fifo_empty = 1'b1; fifo_underflow = 1'b0; fifo_data_out = '0;
    clr();
    step(2);
    chk("rst_rd_en", {31'h0, fifo_rd_en}, 32'h0);
    chk("rst_valid", {31'h0, m_valid}, 32'h0);
    chk("rst_data", {16'h0, m_data}, 32'h0);
    chk("rst_idle", {31'h0, idle}, 32'h1);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_wc", {16'h0, word_count}, 32'h0);
    rst = 1'b0;
    step(1);

    // streaming 1..8
    for (int i = 1; i <= 8; i++) fq.push_back(16'(i));
    step(1);
    clr();
    m_ready = 1'b1; enable = 1'b1; en_cyc = cyc;
    wait_acc(8, 40);
    chk("str_acc", acc_cnt, 8);
    chk("str_rd", rd_cnt, 8);
    chk("str_first_rd", first_rd, en_cyc + 1);
    chk("str_rd_run", last_rd - first_rd, 7);
    chk("str_latency", first_acc - first_rd, 2);
    chk("str_acc_run", last_acc - first_acc, 7);
    chk("str_idle", {31'h0, idle}, 32'h0);
    chk("str_wc", {16'h0, word_count}, wc_exp());

    // random data with random backpressure
    clr();
    begin
      int pushed = 0;
      for (int i = 0; i < 400 && acc_cnt < 30; i++) begin
        m_ready = 1'($urandom_range(0, 1));
        if (pushed < 30 && $urandom_range(0, 2) != 0) begin
          fq.push_back(16'($urandom));
          pushed++;
        end
        step(1);
      end
    end
    chk("rnd_acc", acc_cnt, 30);
    m_ready = 1'b1;
    step(3);
    chk("rnd_drained", exp_q.size(), 0);
    chk("rnd_wc", {16'h0, word_count}, wc_exp());

    // backpressure
    clr();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) fq.push_back(16'hB000 + 16'(i));
    step(10);
    chk("bp_rd", rd_cnt, 2);
    chk("bp_valid", {31'h0, m_valid}, 32'h1);
    chk("bp_data", {16'h0, m_data}, 32'hB000);
    m_ready = 1'b1;
    wait_acc(8, 40);
    chk("bp_acc", acc_cnt, 8);
    chk("bp_no_gap", last_acc - first_acc, 7);

    // flush with enable dropped on a read cycle
    enable = 1'b0;
    step(6);
    chk("fl_pre_idle", {31'h0, idle}, 32'h1);
    for (int i = 0; i < 8; i++) fq.push_back(16'hC000 + 16'(i));
    step(1);
    clr();
    enable = 1'b1;
    step(3);
    chk("fl_rd_same", {31'h0, fifo_rd_en}, 32'h1);
    enable = 1'b0;
    for (int i = 0; i < 20 && !idle; i++) step(1);
    chk("fl_idle", {31'h0, idle}, 32'h1);
    chk("fl_rd", rd_cnt, 3);
    chk("fl_acc", acc_cnt, 3);
    chk("fl_left", fq.size(), 5);
    chk("fl_sb_empty", exp_q.size(), 0);

    // underflow on the first response
    clr();
    uf_req = 1'b1;
    enable = 1'b1;
    wait_acc(4, 30);
    step(5);
    chk("uf_acc", acc_cnt, 4);
    chk("uf_rd", rd_cnt, 5);
    chk("uf_err", {31'h0, err}, 32'h1);
    step(5);
    chk("uf_err_sticky", {31'h0, err}, 32'h1);

    // empty flag held during RUN
    clr();
    force_empty = 1'b1;
    for (int i = 0; i < 4; i++) fq.push_back(16'hD000 + 16'(i));
    step(10);
    chk("emp_rd", rd_cnt, 0);
    chk("emp_valid", {31'h0, m_valid}, 32'h0);
    force_empty = 1'b0;

    // reset mid-RUN with a full buffer
    m_ready = 1'b0;
    step(6);
    chk("mr_valid_pre", {31'h0, m_valid}, 32'h1);
    chk("mr_err_pre", {31'h0, err}, 32'h1);
    chk("mr_wc_pre", {16'h0, word_count}, wc_exp());
    rst = 1'b1;
    #1;
    chk("mr_valid", {31'h0, m_valid}, 32'h0);
    chk("mr_rd_en", {31'h0, fifo_rd_en}, 32'h0);
    chk("mr_err", {31'h0, err}, 32'h0);
    chk("mr_wc", {16'h0, word_count}, 32'h0);
    chk("mr_idle", {31'h0, idle}, 32'h1);
    step(2);
    fq.delete(); exp_q.delete();
    outstanding = 0; exp_wc = 0;
    enable = 1'b0;
    rst = 1'b0;
    step(2);
    chk("mr_post_idle", {31'h0, idle}, 32'h1);

    // counter after 12 pops
    clr();
    for (int i = 0; i < 12; i++) fq.push_back(16'($urandom));
    step(1);
    m_ready = 1'b1; enable = 1'b1;
    wait_acc(12, 60);
    chk("cnt_acc", acc_cnt, 12);
    chk("cnt_wc", {16'h0, word_count}, wc_exp());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Read-side consumer for the synchronous FIFO. It pops words from the FIFO's read port with `rd_en`, tracks the FIFO's one-cycle read latency, and re-presents the data on a valid/ready stream through a 2-entry output buffer. This lets downstream logic apply backpressure without losing words already popped. It sits between the FIFO's `data_out`/`empty`/`underflow` outputs and any stream sink, and sustains one word per cycle.

## Interface
- `FIFO_WIDTH`, 16: data width, equal to the FIFO data width.
- `CNT_WIDTH`, 16: width of the statistics counter.

- `clk`  in  1: rising-edge clock shared with the FIFO.
- `rst`  in  1: asynchronous, active-high reset. One clock, `clk`; all state clears immediately on `rst`.
- `enable`  in  1: high = run; low = stop issuing reads and flush.
- `fifo_empty`  in  1: FIFO `empty` flag.
- `fifo_underflow`  in  1: FIFO `underflow` flag, registered response to a read.
- `fifo_data_out`  in  FIFO_WIDTH: FIFO read data, valid in the cycle after `fifo_rd_en`.
- `fifo_rd_en`  out  1: read strobe to the FIFO (combinational).
- `m_valid`  out  1: output word valid.
- `m_data`  out  FIFO_WIDTH: output word.
- `m_ready`  in  1: sink accepts the word when `m_valid && m_ready`.
- `idle`  out  1: high in IDLE state.
- `err`  out  1: sticky underflow error.
- `word_count`  out  CNT_WIDTH: number of accepted output words (see Configuration).

## Operation
- **States:**
  - IDLE: no reads issued. Goes to RUN when `enable` = 1.
  - RUN: reads are issued when there is room. Goes to FLUSH when `enable` = 0.
  - FLUSH: no reads issued. Goes to IDLE once no read is in flight and the buffer is empty. Goes back to RUN if `enable` = 1.
- **Bookkeeping:**
  - `occ` (0..2) counts words in the output buffer.
  - `inflight` (0/1) is `fifo_rd_en` registered from the previous cycle.
  - `pop` = `m_valid && m_ready`.
- **Read issue:** `fifo_rd_en` = RUN && !`fifo_empty` && (`occ` + `inflight` − `pop` < 2).
- **Capture:** when `inflight` = 1, `fifo_data_out` is written into the buffer tail. The exception is `fifo_underflow` = 1 in that cycle: the word is dropped and `err` is set. `err` clears only on `rst`.
- **Buffer:** 2-entry FIFO, head presented on `m_data`.
  - `m_valid` = (`occ` != 0).
  - When capture and pop happen in the same cycle, `occ` is unchanged and order is preserved.
  - `m_data` must stay stable while `m_valid && !m_ready`.
- **Full buffer:** with `occ` = 2 and no pop, `fifo_rd_en` = 0.
- **Empty FIFO:** with `fifo_empty` = 1, no read is issued, even if room exists.
- **`enable` dropped mid-burst:** the in-flight word is still captured and all buffered words are delivered before IDLE is entered.

## Timing
- **Reset values:** `fifo_rd_en` = 0, `m_valid` = 0, `m_data` = 0, `idle` = 1, `err` = 0, `word_count` = 0, state = IDLE, `occ` = 0, `inflight` = 0.
- **Latency:** `fifo_rd_en` high in cycle N → data captured at the end of N+1 → `m_valid` high in N+2.
- **Throughput:** with `m_ready` held at 1 and the FIFO non-empty, one word per cycle.
- **Enable:** `enable` rising in cycle N → state RUN in N+1 → first `fifo_rd_en` in N+1.
- **Mid-operation reset:** in-flight and buffered words are discarded; the FIFO contents already popped are lost.
- **Counter wrap:** `word_count` wraps modulo 2^CNT_WIDTH.

## Configuration
- **`FIFO_READER_STATS_EN` defined:** `word_count` increments on every `pop` and resets to 0.
- **Not defined:** the counter logic is compiled out and `word_count` is tied to 0.
- Nothing else changes.

## Test plan
- **Reset:** assert `rst` mid-RUN with `occ` = 2 → `m_valid`, `fifo_rd_en`, `err` and `word_count` go to 0 immediately and `idle` = 1.
- **Streaming:** load the FIFO with 0x0001..0x0008, set `enable` = 1 and `m_ready` = 1 → 8 consecutive `fifo_rd_en` cycles, `m_data` = 0x0001..0x0008 on 8 consecutive cycles starting 2 cycles after the first read, `word_count` = 8 (with the macro).
- **Backpressure:** 8 words queued, `m_ready` = 0 → exactly 2 reads issued, `m_valid` = 1, `m_data` = first word held stable. Release `m_ready` → remaining 6 words follow in order with no gaps or duplicates.
- **Flush:** drop `enable` in the same cycle as a `fifo_rd_en` → no further reads, the in-flight word plus buffered words are delivered, then `idle` = 1.
- **Underflow:** force `fifo_underflow` = 1 on a response cycle → that word is not output, `err` = 1 and stays set until `rst`.
- **Empty and compile-out:** with `fifo_empty` = 1 throughout RUN → `fifo_rd_en` never rises and `m_valid` stays 0. Build without `FIFO_READER_STATS_EN` → `word_count` stays 0 after 10 pops.
